// File: rtl/ring_monitor_if.sv
// rtl/ring_monitor_if.sv - handshake bundle between a ring counter and its monitor
// Purpose: groups the ring sample, advance/clear controls and all monitor status outputs.
// Signals:
//   adv, ring_q, clr_err                          driven by the ring side (master)
//   phase, phase_valid, lap_pulse, lap_cnt,
//   err, err_cnt, state                           driven by the monitor (slave)
interface ring_monitor_if #(
  parameter int N     = 3,
  parameter int PW    = 2,
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic             adv;
  logic [N-1:0]     ring_q;
  logic             clr_err;
  logic [PW-1:0]    phase;
  logic             phase_valid;
  logic             lap_pulse;
  logic [LAP_W-1:0] lap_cnt;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output adv, ring_q, clr_err,
    input  phase, phase_valid, lap_pulse, lap_cnt, err, err_cnt, state
  );

  modport slave (
    input  adv, ring_q, clr_err,
    output phase, phase_valid, lap_pulse, lap_cnt, err, err_cnt, state
  );
endinterface

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - one-hot ring counter monitor with lock/fault tracking
// Purpose: encodes the hot bit of a one-hot ring to a phase index, counts laps,
// checks every sample for a legal one-hot value and a legal rotation step, and
// reports SYNC/LOCK/FAULT status. All outputs are registered (latency 1).
// Optional macro RING_MON_RESYNC_EN: FAULT exits on any legal one-hot sample
// instead of only on the ring reset pattern (bit 0 hot).
// Ports:
//   clk  rising-edge clock shared with the ring counter
//   rst  synchronous active-low reset
//   bus  ring_monitor_if.slave: adv, ring_q, clr_err in; phase, phase_valid,
//        lap_pulse, lap_cnt, err, err_cnt, state out
module ring_monitor #(
  parameter int N     = 3,
  parameter int PW    = 2,
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input logic            clk,
  input logic            rst,
  ring_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [N-1:0]     RING_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [LAP_W-1:0] LAP_ONE  = {{(LAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             lap_pulse_q, lap_pulse_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [PW-1:0]    hot_idx;
  logic             hot_legal;
  logic [N-1:0]     ring_next;
  logic [N-1:0]     ring_expect;
  logic             fault_exit;

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.ring_q[i]) hot_idx = i[PW-1:0];
    end
  end

  assign hot_legal   = ($countones(bus.ring_q) == 1);
  assign ring_next   = {prev_q[N-2:0], prev_q[N-1]};
  // While held, the ring must not move; while advancing, it must rotate by one.
  assign ring_expect = bus.adv ? ring_next : prev_q;

`ifdef RING_MON_RESYNC_EN
  assign fault_exit = hot_legal;
`else
  assign fault_exit = (bus.ring_q == RING_ONE);
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    phase_d     = phase_q;
    valid_d     = valid_q;
    lap_pulse_d = 1'b0;
    lap_cnt_d   = lap_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    // Clear first so an error detected on the same edge lands on a zeroed count.
    if (bus.clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    case (state_q)
      SYNC: begin
        if (hot_legal) begin
          prev_d  = bus.ring_q;
          phase_d = hot_idx;
          valid_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // prev_q is always one-hot here, so equality also implies legality.
        if (bus.ring_q == ring_expect) begin
          if (bus.adv) begin
            prev_d  = bus.ring_q;
            phase_d = hot_idx;
            if (prev_q[N-1] && bus.ring_q[0]) begin
              lap_cnt_d   = lap_cnt_q + LAP_ONE;
              lap_pulse_d = 1'b1;
            end
          end
        end else begin
          err_d     = 1'b1;
          if (bus.clr_err)          err_cnt_d = ERR_ONE;
          else if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_ONE;
          valid_d   = 1'b0;
          state_d   = FAULT;
        end
      end
      FAULT: begin
        if (fault_exit) state_d = SYNC;
      end
      default: begin
        state_d = SYNC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      lap_pulse_q <= 1'b0;
      lap_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      lap_pulse_q <= lap_pulse_d;
      lap_cnt_q   <= lap_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.lap_pulse   = lap_pulse_q;
  assign bus.lap_cnt     = lap_cnt_q;
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - scoreboard bench for ring_monitor
module tb_ring_monitor;
  localparam int N     = 3;
  localparam int PW    = 2;
  localparam int LAP_W = 8;
  localparam int ERR_W = 4;

  typedef struct packed {
    logic [1:0]       st;
    logic [PW-1:0]    ph;
    logic             pv;
    logic             lp;
    logic [LAP_W-1:0] lc;
    logic             er;
    logic [ERR_W-1:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ring_monitor_if #(.N(N), .PW(PW), .LAP_W(LAP_W), .ERR_W(ERR_W)) ifc ();

  ring_monitor #(.N(N), .PW(PW), .LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  // Reference model: phase tracked as an integer hot index, counters as integers.
  int m_state = 0;
  int m_pidx  = 0;
  int m_phase = 0;
  int m_valid = 0;
  int m_pulse = 0;
  int m_lap   = 0;
  int m_err   = 0;
  int m_ecnt  = 0;

  task automatic model_step(input logic r, input logic a, input logic c, input logic [N-1:0] rq);
    int ones, idx;
    bit ok;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < N; i++) if (rq[i]) begin ones++; idx = i; end
    if (!r) begin
      m_state = 0; m_pidx = 0; m_phase = 0; m_valid = 0;
      m_pulse = 0; m_lap = 0; m_err = 0; m_ecnt = 0;
      return;
    end
    m_pulse = 0;
    if (c) begin m_err = 0; m_ecnt = 0; end
    if (m_state == 0) begin
      if (ones == 1) begin
        m_pidx = idx; m_phase = idx; m_valid = 1; m_state = 1;
      end
    end else if (m_state == 1) begin
      ok = (ones == 1) && (a ? (idx == (m_pidx + 1) % N) : (idx == m_pidx));
      if (ok) begin
        if (a) begin
          if (m_pidx == N - 1) begin
            m_lap = (m_lap + 1) % (1 << LAP_W);
            m_pulse = 1;
          end
          m_pidx = idx; m_phase = idx;
        end
      end else begin
        m_err = 1;
        m_ecnt = (m_ecnt + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_ecnt + 1;
        m_valid = 0;
        m_state = 2;
      end
    end else begin
`ifdef RING_MON_RESYNC_EN
      if (ones == 1) m_state = 0;
`else
      if (ones == 1 && idx == 0) m_state = 0;
`endif
    end
  endtask

  function automatic logic [N-1:0] hot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic r, input logic a, input logic c, input logic [N-1:0] rq);
    exp_t e;
    @(negedge clk);
    rst         = r;
    ifc.adv     = a;
    ifc.clr_err = c;
    ifc.ring_q  = rq;
    model_step(r, a, c, rq);
    e.st = m_state[1:0];
    e.ph = m_phase[PW-1:0];
    e.pv = m_valid[0];
    e.lp = m_pulse[0];
    e.lc = m_lap[LAP_W-1:0];
    e.er = m_err[0];
    e.ec = m_ecnt[ERR_W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic dchk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: every output sample is compared against the oldest expectation.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{st: ifc.state, ph: ifc.phase, pv: ifc.phase_valid, lp: ifc.lap_pulse,
                lc: ifc.lap_cnt, er: ifc.err, ec: ifc.err_cnt};
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL outputs @%0t: got st=%0d ph=%0d pv=%0d lp=%0d lc=%0d er=%0d ec=%0d expected st=%0d ph=%0d pv=%0d lp=%0d lc=%0d er=%0d ec=%0d",
                      $time, act.st, act.ph, act.pv, act.lp, act.lc, act.er, act.ec,
                      e.st, e.ph, e.pv, e.lp, e.lc, e.er, e.ec);
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    logic a, c, r;
    ifc.adv = 1'b1;
    ifc.clr_err = 1'b0;
    ifc.ring_q = 3'b011;

    // Reset held for two edges with an illegal ring value.
    step(1'b0, 1'b1, 1'b0, 3'b011);
    step(1'b0, 1'b1, 1'b0, 3'b011);
    settle();
    dchk("reset_state", ifc.state, 0);
    dchk("reset_err_cnt", ifc.err_cnt, 0);

    // Normal run: 31 samples give 10 wrap steps.
    for (int k = 0; k <= 30; k++) step(1'b1, 1'b1, 1'b0, hot(k % N));
    settle();
    dchk("ten_laps", ifc.lap_cnt, 10);
    dchk("ten_laps_err", ifc.err, 0);

    // Illegal value, recover, then skipped step.
    step(1'b1, 1'b1, 1'b0, 3'b011);
    settle();
    dchk("illegal_state", ifc.state, 2);
    dchk("illegal_phase_held", ifc.phase, 0);
    step(1'b1, 1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b1, 1'b0, 3'b100);
    settle();
    dchk("skip_err_cnt", ifc.err_cnt, 2);
    step(1'b1, 1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b1, 1'b0, 3'b001);

    // Hold: stable then a change while adv=0.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 3'b001);
    step(1'b1, 1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b0, 1'b0, 3'b100);
    settle();
    dchk("hold_move_err_cnt", ifc.err_cnt, 3);
    step(1'b1, 1'b1, 1'b0, 3'b001);

    // Lap counter wrap after 256 laps.
    step(1'b0, 1'b1, 1'b0, 3'b001);
    for (int k = 0; k <= 256 * N; k++) step(1'b1, 1'b1, 1'b0, hot(k % N));
    settle();
    dchk("lap_wrap_cnt", ifc.lap_cnt, 0);
    dchk("lap_wrap_pulse", ifc.lap_pulse, 1);

    // Error counter saturation over 20 fault/recover cycles.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 3'b011);
      step(1'b1, 1'b1, 1'b0, 3'b001);
      step(1'b1, 1'b1, 1'b0, 3'b001);
    end
    settle();
    dchk("err_sat", ifc.err_cnt, 15);

    // Clear racing a new error.
    step(1'b1, 1'b1, 1'b1, 3'b011);
    settle();
    dchk("clr_race_err", ifc.err, 1);
    dchk("clr_race_cnt", ifc.err_cnt, 1);

`ifdef RING_MON_RESYNC_EN
    step(1'b1, 1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b1, 1'b0, 3'b010);
    settle();
    dchk("resync_state", ifc.state, 1);
    dchk("resync_phase", ifc.phase, 1);
`else
    step(1'b1, 1'b1, 1'b0, 3'b010);
    settle();
    dchk("no_resync_state", ifc.state, 2);
    step(1'b1, 1'b1, 1'b0, 3'b001);
`endif

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) != 0);
      a = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      if (m_state == 1 && $urandom_range(0, 9) < 8)
        rq = hot(a ? (m_pidx + 1) % N : m_pidx);
      else if (m_state != 1 && $urandom_range(0, 9) < 5)
        rq = 3'b001;
      else
        rq = 3'($urandom_range(0, 7));
      step(r, a, c, rq);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Sits directly downstream of the one-hot ring counter and consumes its parallel one-hot output.
- Encodes the hot bit to a binary phase index and counts full rotations (laps).
- Checks every sample for a legal one-hot value and a legal rotation step; illegal steps are flagged.
- A three-state FSM drives lock/fault status, so downstream phase-sequenced logic can trust the phase index.

Parameters:
- N, 3, ring width (number of one-hot bits); N >= 2.
- PW, 2, phase index width; must satisfy 2^PW >= N.
- LAP_W, 8, lap counter width.
- ERR_W, 4, saturating error counter width.

Ports:
- clk  input  1  rising-edge clock, same clock as the ring counter.
- rst  input  1  synchronous, active-low reset.
- adv  input  1  1 = the ring advanced on this edge (tie 1 for a free-running ring); 0 = the ring is expected to hold.
- ring_q  input  N  one-hot ring output; bit i hot advances to bit (i+1) mod N.
- clr_err  input  1  one-cycle request to clear err and err_cnt.
- phase  output  PW  binary index of the hot bit in the last legal sample.
- phase_valid  output  1  1 while in LOCK.
- lap_pulse  output  1  one-cycle pulse on each bit N-1 -> bit 0 step.
- lap_cnt  output  LAP_W  lap count, wraps modulo 2^LAP_W.
- err  output  1  sticky error flag.
- err_cnt  output  ERR_W  error count, saturates at all-ones.
- state  output  2  FSM state: SYNC=0, LOCK=1, FAULT=2.

Behaviour:
- One clock; reset is synchronous and active-low.
- All outputs are registered and reflect the ring_q sampled on the previous rising edge (latency 1).
- Reset (rst=0 at a clock edge) produces: state=SYNC, phase=0, phase_valid=0, lap_pulse=0, lap_cnt=0, err=0, err_cnt=0, and internal prev=0.
- Reset has priority over all other inputs, including mid-lap or while in FAULT.
- legal(x) means exactly one bit of x is set. next(prev) means prev rotated left by one within N bits.
- SYNC:
  - If legal(ring_q): capture prev<=ring_q, phase<=index, phase_valid<=1, go to LOCK.
  - Otherwise stay in SYNC. No errors are counted in SYNC.
- LOCK, adv=1:
  - Expect ring_q == next(prev). On match: update prev and phase.
  - If prev[N-1]=1 and ring_q[0]=1: lap_cnt<=lap_cnt+1 (wraps) and lap_pulse<=1 for exactly one cycle.
- LOCK, adv=0: expect ring_q == prev. On match, hold all outputs.
- LOCK, any mismatch (illegal value, skipped step, backward step, or change while adv=0):
  - err<=1, err_cnt<=sat(err_cnt+1), phase_valid<=0, go to FAULT.
  - phase, lap_cnt and prev hold their last-good values.
- FAULT:
  - Exits to SYNC when ring_q == 1 (bit 0 hot, the ring's reset pattern).
  - No further error counting while in FAULT; lap_cnt frozen.
- clr_err=1 clears err and err_cnt to 0 on the same edge.
  - If a new error is detected on that same edge: result is err=1, err_cnt=1.
- lap_pulse is 0 on every cycle without a wrap step, including the SYNC->LOCK entry cycle even if that entry sample is bit 0.
- N=2 case: the only legal steps are 01<->10; every 10->01 step counts a lap.

Optional Feature:
- Macro: RING_MON_RESYNC_EN.
- Defined: FAULT exits to SYNC on any legal one-hot ring_q. The next cycle then re-locks at that phase, allowing mid-lap recovery.
- Undefined: FAULT exits only on ring_q == 1, as specified in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 edges with ring_q=3'b011 -> state=0, phase=0, phase_valid=0, lap_cnt=0, err=0, err_cnt=0.
- Normal run (N=3, adv=1): ring_q 001,010,100,001,... -> LOCK one cycle after the first sample; phase 0,1,2,0; lap_pulse high exactly once per 100->001 step; after 10 laps lap_cnt=10, err=0.
- Illegal and skip faults: in LOCK apply 011 -> next cycle state=2, err=1, err_cnt=1, phase_valid=0, phase/lap_cnt held; recover with 001 -> SYNC -> LOCK; then apply skip 001->100 -> err_cnt=2.
- Hold check: adv=0 with ring_q stable for 5 cycles -> no change in any output; adv=0 with ring_q changing 010->100 -> FAULT, err_cnt incremented.
- Wrap/saturation (LAP_W=8, ERR_W=4): 256 laps -> lap_cnt=0 with lap_pulse still asserted; 20 fault/recover cycles -> err_cnt=15 and held.
- Clear race: clr_err=1 on the same edge as a detected error -> err=1, err_cnt=1. With RING_MON_RESYNC_EN defined, FAULT plus ring_q=010 -> SYNC then LOCK with phase=1.
